// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
//   DATA_WIDTH      payload bits per frame, LSB first
//   PRESCALE_WIDTH  width of the Prescale input (oversampling ratio, max 32)
//   rx_state_e      receiver frame state
//   PAR_EVEN/ODD    PAR_TYP encodings
package uart_pkg;

   localparam int unsigned DATA_WIDTH     = 8;
   localparam int unsigned PRESCALE_WIDTH = 6;
   localparam int unsigned BIT_CNT_WIDTH  = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // 2-of-3 vote used to decide a bit from its three mid-bit samples
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Serial line, configuration and parallel result of the UART receiver.
//   master: drives RX_IN/Prescale/PAR_EN/PAR_TYP, observes the result
//   slave : the receiver; drives P_DATA/data_valid/par_err/stp_err
interface uart_rx_frontend_if;
   import uart_pkg::*;

   logic                      RX_IN;
   logic [PRESCALE_WIDTH-1:0] Prescale;
   logic                      PAR_EN;
   logic                      PAR_TYP;
   logic [DATA_WIDTH-1:0]     P_DATA;
   logic                      data_valid;
   logic                      par_err;
   logic                      stp_err;

   modport master (
      output RX_IN, Prescale, PAR_EN, PAR_TYP,
      input  P_DATA, data_valid, par_err, stp_err
   );

   modport slave (
      input  RX_IN, Prescale, PAR_EN, PAR_TYP,
      output P_DATA, data_valid, par_err, stp_err
   );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: runs edge_cnt 0..P-1, captures RX_IN at P/2-1, P/2
// and P/2+1, and strobes bit_done at edge_cnt = P-1 with the majority value.
//   CLK, RST     clock, synchronous active-high reset
//   RX_IN        serial line
//   P            even oversampling ratio latched by the frame controller
//   run          frame in progress (edge_cnt held at 0 otherwise)
//   sampled_bit  majority of the three captured samples (decoded from registers)
//   bit_done     high on the last edge_cnt cycle of a bit (decoded from registers)
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] P,
   input  logic                      run,
   output logic                      sampled_bit,
   output logic                      bit_done
);

   logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
   logic [2:0]                r_samp;
   logic [PRESCALE_WIDTH-1:0] w_half;

   assign w_half      = P >> 1;
   assign bit_done    = run && (r_edge_cnt == (P - PRESCALE_WIDTH'(1)));
   assign sampled_bit = majority3(r_samp[0], r_samp[1], r_samp[2]);

   // Edge counter and mid-bit sample capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_edge_cnt <= '0;
         r_samp     <= '0;
      end else if (!run) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= bit_done ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
         if (r_edge_cnt == (w_half - PRESCALE_WIDTH'(1))) r_samp[0] <= RX_IN;
         if (r_edge_cnt == w_half)                         r_samp[1] <= RX_IN;
         if (r_edge_cnt == (w_half + PRESCALE_WIDTH'(1)))  r_samp[2] <= RX_IN;
      end
   end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver front end: frame FSM, LSB-first shift register, parity check
// and registered result pulses. One result pulse per completed frame.
//   CLK, RST  UART oversampling clock, synchronous active-high reset
//   bus       slave side of uart_rx_frontend_if (RX_IN and config in;
//             P_DATA, data_valid, par_err, stp_err out, all registered)
module uart_rx_frontend
   import uart_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   uart_rx_frontend_if.slave   bus
);

   rx_state_e                 r_state;
   rx_state_e                 w_state_nx;
   logic [PRESCALE_WIDTH-1:0] r_p;
   logic                      r_par_en;
   logic                      r_par_typ;
   logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic                      r_par_bad;
   logic [DATA_WIDTH-1:0]     r_p_data;
   logic                      r_data_valid;
   logic                      r_par_err;
   logic                      r_stp_err;

   logic w_start;
   logic w_run;
   logic w_sampled;
   logic w_bit_done;
   logic w_last_data;

   // c0: falling line seen while idle; the sampler counts this cycle as edge 0
   assign w_start     = (r_state == IDLE) && !bus.RX_IN;
   assign w_run       = (r_state != IDLE) || w_start;
   assign w_last_data = (r_bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1));

   uart_rx_sampler u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (bus.RX_IN),
      .P           (r_p),
      .run         (w_run),
      .sampled_bit (w_sampled),
      .bit_done    (w_bit_done)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE:    if (w_start) w_state_nx = START;
         START:   if (w_bit_done) w_state_nx = w_sampled ? IDLE : DATA;
         DATA:    if (w_bit_done && w_last_data) w_state_nx = r_par_en ? PARITY : STOP;
         PARITY:  if (w_bit_done) w_state_nx = STOP;
         STOP:    if (w_bit_done) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Config latch, data path and result pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_p          <= '0;
         r_par_en     <= 1'b0;
         r_par_typ    <= PAR_EVEN;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_bad    <= 1'b0;
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         if (w_start) begin
            // Prescale LSB is forced to 0 so P is always even
            r_p       <= bus.Prescale & ~PRESCALE_WIDTH'(1);
            r_par_en  <= bus.PAR_EN;
            r_par_typ <= bus.PAR_TYP;
            r_bit_cnt <= '0;
            r_par_bad <= 1'b0;
         end
         if (w_bit_done) begin
            case (r_state)
               DATA: begin
                  r_shift   <= {w_sampled, r_shift[DATA_WIDTH-1:1]};
                  r_bit_cnt <= r_bit_cnt + BIT_CNT_WIDTH'(1);
               end
               PARITY: r_par_bad <= w_sampled != (^r_shift ^ r_par_typ);
               STOP: begin
                  // Framing error outranks parity error; data only on a clean frame
                  if (!w_sampled)     r_stp_err <= 1'b1;
                  else if (r_par_bad) r_par_err <= 1'b1;
                  else begin
                     r_p_data     <= r_shift;
                     r_data_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.P_DATA     = r_p_data;
   assign bus.data_valid = r_data_valid;
   assign bus.par_err    = r_par_err;
   assign bus.stp_err    = r_stp_err;

endmodule
